// File: rtl/rf_wr_arbiter.sv
// Register-file write-port controller: optional post-reset clear of x1..x31, then core/debug
// arbitration with debug starvation protection. Define RF_CLEAR_EN to build the clear sequence.
module rf_wr_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_wr_valid_i,
    input  logic [4:0]  core_wr_addr_i,
    input  logic [31:0] core_wr_data_i,
    output logic        core_wr_ready_o,
    input  logic        dbg_wr_valid_i,
    input  logic [4:0]  dbg_wr_addr_i,
    input  logic [31:0] dbg_wr_data_i,
    output logic        dbg_wr_ready_o,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_addr_o,
    output logic [31:0] rf_wr_data_o,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

`ifdef RF_CLEAR_EN
    typedef enum logic [1:0] {StInit, StClear, StArb} state_e;
    logic [4:0] clear_cnt_q, clear_cnt_d;
`else
    typedef enum logic [1:0] {StInit, StArb} state_e;
`endif

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       dbg_gnt, core_gnt;

    always_comb begin
        dbg_gnt  = (state_q == StArb) && dbg_wr_valid_i &&
                   (!core_wr_valid_i || (starve_q == StarveMax));
        core_gnt = (state_q == StArb) && !dbg_gnt && core_wr_valid_i;
    end

    always_comb begin
        rf_wr_en_o      = 1'b0;
        rf_wr_addr_o    = 5'd0;
        rf_wr_data_o    = 32'd0;
        core_wr_ready_o = core_gnt;
        dbg_wr_ready_o  = dbg_gnt;
        grant_o         = {dbg_gnt, core_gnt};
        busy_o          = (state_q != StArb);
`ifdef RF_CLEAR_EN
        if (state_q == StClear) begin
            rf_wr_en_o   = 1'b1;
            rf_wr_addr_o = clear_cnt_q;
        end
`endif
        // A granted write to x0 is still accepted; only the enable is suppressed.
        if (dbg_gnt) begin
            rf_wr_en_o   = (dbg_wr_addr_i != 5'd0);
            rf_wr_addr_o = dbg_wr_addr_i;
            rf_wr_data_o = dbg_wr_data_i;
        end else if (core_gnt) begin
            rf_wr_en_o   = (core_wr_addr_i != 5'd0);
            rf_wr_addr_o = core_wr_addr_i;
            rf_wr_data_o = core_wr_data_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
`ifdef RF_CLEAR_EN
        clear_cnt_d = clear_cnt_q;
`endif
        unique case (state_q)
`ifdef RF_CLEAR_EN
            StInit:  state_d = StClear;
            StClear: begin
                if (clear_cnt_q == 5'd31) begin
                    state_d = StArb;
                end else begin
                    clear_cnt_d = clear_cnt_q + 5'd1;
                end
            end
`else
            StInit:  state_d = StArb;
`endif
            StArb: begin
                // Debug lost this cycle only if it was valid and the core took the port.
                if (dbg_wr_valid_i && !dbg_gnt) begin
                    starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
                end else begin
                    starve_d = 4'd0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            starve_q    <= 4'd0;
`ifdef RF_CLEAR_EN
            clear_cnt_q <= 5'd1;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
`ifdef RF_CLEAR_EN
            clear_cnt_q <= clear_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: reset/clear sequence, vector table, starvation pattern,
// randomized traffic against a cycle-counting reference model, and mid-run reset.
module tb_rf_wr_arbiter;

    localparam int unsigned StarveMax = 4;
`ifdef RF_CLEAR_EN
    localparam int ArbStart = 32;
    localparam bit HasClear = 1'b1;
`else
    localparam int ArbStart = 1;
    localparam bit HasClear = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cv = 1'b0, dv = 1'b0;
    logic [4:0]  ca = '0, da = '0;
    logic [31:0] cd = '0, dd = '0;
    logic        core_rdy, dbg_rdy, wr_en, busy;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  grant;

    rf_wr_arbiter #(.STARVE_MAX(StarveMax)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .core_wr_valid_i (cv),
        .core_wr_addr_i  (ca),
        .core_wr_data_i  (cd),
        .core_wr_ready_o (core_rdy),
        .dbg_wr_valid_i  (dv),
        .dbg_wr_addr_i   (da),
        .dbg_wr_data_i   (dd),
        .dbg_wr_ready_o  (dbg_rdy),
        .rf_wr_en_o      (wr_en),
        .rf_wr_addr_o    (wr_addr),
        .rf_wr_data_o    (wr_data),
        .grant_o         (grant),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycles since edge 0, and consecutive cycles debug has lost.
    int m_cyc = 0;
    int m_wait = 0;
    logic        e_en, e_cr, e_dr, e_busy;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_g;

    typedef struct {
        logic        cv; logic [4:0] ca; logic [31:0] cd;
        logic        dv; logic [4:0] da; logic [31:0] dd;
        logic        en; logic [4:0] addr; logic [31:0] data;
        logic        cr; logic dr; logic [1:0] g;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit dbg_wins();
        return dv && (!cv || m_wait == int'(StarveMax));
    endfunction

    task automatic model_eval();
        bit dw, cw;
        e_en = 0; e_addr = 0; e_data = 0; e_cr = 0; e_dr = 0; e_g = 0;
        e_busy = (m_cyc < ArbStart);
        if (HasClear && m_cyc >= 1 && m_cyc <= 31) begin
            e_en = 1; e_addr = 5'(m_cyc);
        end
        if (m_cyc >= ArbStart) begin
            dw = dbg_wins();
            cw = !dw && cv;
            e_dr = dw; e_cr = cw; e_g = {dw, cw};
            if (dw) begin e_en = (da != 0); e_addr = da; e_data = dd; end
            else if (cw) begin e_en = (ca != 0); e_addr = ca; e_data = cd; end
        end
    endtask

    task automatic check_model(input string tag);
        model_eval();
        check({tag, ".en"}, 32'(wr_en), 32'(e_en));
        check({tag, ".core_rdy"}, 32'(core_rdy), 32'(e_cr));
        check({tag, ".dbg_rdy"}, 32'(dbg_rdy), 32'(e_dr));
        check({tag, ".grant"}, 32'(grant), 32'(e_g));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        if (e_en || e_g == 2'b00) begin
            check({tag, ".addr"}, 32'(wr_addr), 32'(e_addr));
            check({tag, ".data"}, wr_data, e_data);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".en"}, 32'(wr_en), 0);
        check({tag, ".addr"}, 32'(wr_addr), 0);
        check({tag, ".data"}, wr_data, 0);
        check({tag, ".core_rdy"}, 32'(core_rdy), 0);
        check({tag, ".dbg_rdy"}, 32'(dbg_rdy), 0);
        check({tag, ".grant"}, 32'(grant), 0);
        check({tag, ".busy"}, 32'(busy), 1);
    endtask

    // Advance one rising edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        bit dw;
        @(posedge clk);
        if (!rst_ni) begin
            m_cyc = 0; m_wait = 0;
        end else begin
            if (m_cyc >= ArbStart) begin
                dw = dbg_wins();
                if (dv && !dw) m_wait = (m_wait < int'(StarveMax)) ? m_wait + 1 : m_wait;
                else m_wait = 0;
            end
            if (m_cyc < 100000) m_cyc++;
        end
        #1;
    endtask

    initial begin
        vt[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 1, 0, 2'b01};
        vt[1] = '{1, 5'd0, 32'h00001234, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 2'b01};
        vt[2] = '{0, 5'd0, 32'h0, 1, 5'd9, 32'hCAFEF00D, 1, 5'd9, 32'hCAFEF00D, 0, 1, 2'b10};
        vt[3] = '{0, 5'd0, 32'h0, 1, 5'd0, 32'h00000042, 0, 5'd0, 32'h0, 0, 1, 2'b10};
        vt[4] = '{0, 5'd3, 32'h0000AAAA, 0, 5'd4, 32'h0000BBBB, 0, 5'd0, 32'h0, 0, 0, 2'b00};
        vt[5] = '{1, 5'd12, 32'h11111111, 1, 5'd13, 32'h22222222,
                  1, 5'd12, 32'h11111111, 1, 0, 2'b01};
        vt[6] = '{0, 5'd0, 32'h0, 1, 5'd20, 32'h00000033, 1, 5'd20, 32'h00000033, 0, 1, 2'b10};
        vt[7] = '{1, 5'd31, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 5'd31, 32'hFFFFFFFF, 1, 0, 2'b01};

        // Reset, then release with the core requesting throughout.
        repeat (3) tick();
        cv = 1; ca = HasClear ? 5'd3 : 5'd7; cd = 32'h55;
        #4 check_reset_vals("reset");
        @(negedge clk); #1;
        rst_ni = 1;
        #2 check_reset_vals("cycle0");
        tick();
        if (HasClear) begin
            for (int c = 1; c <= 31; c++) begin
                #3;
                check($sformatf("clear%0d.en", c), 32'(wr_en), 1);
                check($sformatf("clear%0d.addr", c), 32'(wr_addr), 32'(c));
                check($sformatf("clear%0d.data", c), wr_data, 0);
                check($sformatf("clear%0d.core_rdy", c), 32'(core_rdy), 0);
                check($sformatf("clear%0d.busy", c), 32'(busy), 1);
                tick();
            end
        end
        #3;
        check("first_arb.core_rdy", 32'(core_rdy), 1);
        check("first_arb.grant", 32'(grant), 32'h1);
        check("first_arb.addr", 32'(wr_addr), 32'(ca));
        check("first_arb.en", 32'(wr_en), 1);
        check("first_arb.busy", 32'(busy), 0);
        cv = 0;
        tick();

        foreach (vt[i]) begin
            cv = vt[i].cv; ca = vt[i].ca; cd = vt[i].cd;
            dv = vt[i].dv; da = vt[i].da; dd = vt[i].dd;
            #3;
            check($sformatf("vec%0d.en", i), 32'(wr_en), 32'(vt[i].en));
            check($sformatf("vec%0d.core_rdy", i), 32'(core_rdy), 32'(vt[i].cr));
            check($sformatf("vec%0d.dbg_rdy", i), 32'(dbg_rdy), 32'(vt[i].dr));
            check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vt[i].g));
            if (vt[i].en || vt[i].g == 2'b00) begin
                check($sformatf("vec%0d.addr", i), 32'(wr_addr), 32'(vt[i].addr));
                check($sformatf("vec%0d.data", i), wr_data, vt[i].data);
            end
            tick();
        end

        // Continuous contention: core x4, debug x1, repeating.
        cv = 1; ca = 5'd1; cd = 32'hC0; dv = 1; da = 5'd2; dd = 32'hD0;
        for (int i = 0; i < 15; i++) begin
            #3 check($sformatf("starve%0d.grant", i), 32'(grant),
                     (i % 5 == 4) ? 32'h2 : 32'h1);
            tick();
        end
        cv = 0; dv = 0;
        tick();

        // Random traffic; a requester that was not accepted holds its request.
        for (int i = 0; i < 400; i++) begin
            if (!cv || core_rdy) begin
                cv = ($urandom_range(0, 3) != 0); ca = 5'($urandom_range(0, 31)); cd = $urandom;
            end
            if (!dv || dbg_rdy) begin
                dv = ($urandom_range(0, 2) != 0); da = 5'($urandom_range(0, 31)); dd = $urandom;
            end
            #3 check_model($sformatf("rand%0d", i));
            tick();
        end

        // Reset mid-run: during the x10 clear write, or mid-ARB without the clear.
        cv = 1; ca = 5'd7; cd = 32'h77; dv = 0;
        if (HasClear) begin
            rst_ni = 0; #1; m_cyc = 0; m_wait = 0;
            tick();
            @(negedge clk); #1 rst_ni = 1;
            for (int c = 0; c < 10; c++) tick();
            #2 check("midclr.addr_before", 32'(wr_addr), 10);
        end else begin
            #2 check("midarb.core_rdy_before", 32'(core_rdy), 1);
        end
        rst_ni = 0;
        #1 check_reset_vals("midrst");
        m_cyc = 0; m_wait = 0;
        tick();
        @(negedge clk); #1 rst_ni = 1;
        #2 check_model("rerelease.c0");
        tick();
        #3 check_model("rerelease.c1");
        if (HasClear) check("rerelease.addr1", 32'(wr_addr), 1);
        else check("rerelease.core_rdy", 32'(core_rdy), 1);
        for (int c = 2; c <= ArbStart; c++) tick();
        #3 check_model("rerelease.arb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
